// File: rtl/uart_rx_fifo_if.sv
// Byte stream and status bundle between the UART receiver and its consumer.
// The receiver drives data, occupancy and error flags. The consumer drives
// the pop strobe and the error-clear strobe.
interface uart_rx_fifo_if #(
  parameter int FIFO_DEPTH = 16
);
  logic [7:0]                      rx_data;
  logic                            rx_valid;
  logic                            rx_ready;
  logic [$clog2(FIFO_DEPTH+1)-1:0] rx_count;
  logic                            overrun;
  logic                            frame_err;
  logic                            err_clr;
  logic                            busy;

  modport master (
    output rx_data, rx_valid, rx_count, overrun, frame_err, busy,
    input  rx_ready, err_clr
  );

  modport slave (
    input  rx_data, rx_valid, rx_count, overrun, frame_err, busy,
    output rx_ready, err_clr
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with a first-word-fall-through byte FIFO.
// The async line is synchronized and sampled at mid-bit. Good bytes are queued
// for a valid/ready consumer. Framing errors and overruns raise sticky flags.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           uart_rx,
  uart_rx_fifo_if.master bus
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]    CNT_FULL = CW'(FIFO_DEPTH);

  localparam logic [2:0] ST_WAIT_IDLE = 3'd0;
  localparam logic [2:0] ST_IDLE      = 3'd1;
  localparam logic [2:0] ST_START     = 3'd2;
  localparam logic [2:0] ST_DATA      = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;

  logic             sync1;
  logic             rxs;
  logic [1:0]       sync_ok;
  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shreg;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             overrun_q;
  logic             frame_err_q;

  logic             sample_stop;
  logic             push;
  logic             ferr_set;
  logic             valid;
  logic             full;
  logic             pop;
  logic             push_ok;
  logic             ovr_set;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= uart_rx;
      rxs   <= sync1;
    end
  end

  // Marks when the synchronizer holds real line samples again after reset, so
  // WAIT_IDLE is not fooled by the flops' forced-high reset value.
  always_ff @(posedge clk) begin
    if (rst) sync_ok <= 2'b00;
    else     sync_ok <= {sync_ok[0], 1'b1};
  end

  // Receiver FSM: start-bit qualification, mid-bit data sampling, stop check.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_WAIT_IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      case (state)
        ST_WAIT_IDLE: if (sync_ok[1] && rxs) state <= ST_IDLE;
        ST_IDLE: begin
          if (!rxs) begin
            state <= ST_START;
            cnt   <= '0;
          end
        end
        ST_START: begin
          if (cnt == CNT_HALF) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rxs ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (idx == 3'd7) state <= ST_STOP;
            else             idx   <= idx + 3'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= rxs ? ST_IDLE : ST_WAIT_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_WAIT_IDLE;
      endcase
    end
  end

  // Data bits land LSB first at the middle of each bit period.
  always_ff @(posedge clk) begin
    if (state == ST_DATA && cnt == CNT_LAST) shreg[idx] <= rxs;
  end

  // Push/pop decisions; a push into a full FIFO only survives if a pop frees a slot.
  always_comb begin
    sample_stop = (state == ST_STOP) && (cnt == CNT_LAST);
    push        = sample_stop && rxs;
    ferr_set    = sample_stop && !rxs;
    valid       = (count != '0);
    full        = (count == CNT_FULL);
    pop         = valid && bus.rx_ready;
    push_ok     = push && (!full || pop);
    ovr_set     = push && full && !pop;
  end

  // FIFO storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= shreg;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a new error in the clear cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      overrun_q   <= ovr_set  | (overrun_q   & ~bus.err_clr);
      frame_err_q <= ferr_set | (frame_err_q & ~bus.err_clr);
    end
  end

  assign bus.rx_valid  = valid;
  assign bus.rx_data   = valid ? mem[rd_ptr] : 8'h00;
  assign bus.rx_count  = count;
  assign bus.overrun   = overrun_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state != ST_IDLE);
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo. It uses a short bit period to keep the
// runtime small. A queue-based model predicts which bytes come out and in what order.
module tb_uart_rx_fifo;
  localparam int CPB = 16;
  localparam int D   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_rx = 1'b1;

  uart_rx_fifo_if #(.FIFO_DEPTH(D)) bus ();

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(D)) dut (
    .clk     (clk),
    .rst     (rst),
    .uart_rx (uart_rx),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] rcvq[$];
  logic [7:0] expq[$];

  // Record every completed handshake; inputs change only just after posedge.
  always @(negedge clk) begin
    if (!rst && bus.rx_valid && bus.rx_ready) rcvq.push_back(bus.rx_data);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_lvl);
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(CPB);
    end
    uart_rx = stop_lvl;
    tick(CPB);
    uart_rx = 1'b1;
  endtask

  task automatic drain();
    bus.rx_ready = 1'b1;
    tick(D + 4);
    bus.rx_ready = 1'b0;
    tick(2);
  endtask

  task automatic pulse_clr();
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus.rx_valid); end
    checks++; if (bus.rx_count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.rx_count); end
    checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %02h want 00", bus.rx_data); end
    checks++; if ({bus.overrun, bus.frame_err} !== 2'b00) begin errors++; $display("FAIL reset_flags got %02b want 00", {bus.overrun, bus.frame_err}); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %0b want 1", bus.busy); end
    rst = 1'b0;
    tick(6);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %0b want 0", bus.busy); end
  endtask

  task automatic test_single();
    rcvq.delete();
    bus.rx_ready = 1'b1;
    send_frame(8'h63, 1'b1);
    tick(CPB);
    bus.rx_ready = 1'b0;
    tick(2);
    checks++; if (rcvq.size() !== 1) begin errors++; $display("FAIL single_count got %0d want 1", rcvq.size()); end
    else begin
      checks++; if (rcvq[0] !== 8'h63) begin errors++; $display("FAIL single_data got %02h want 63", rcvq[0]); end
    end
    checks++; if ({bus.overrun, bus.frame_err} !== 2'b00) begin errors++; $display("FAIL single_flags got %02b want 00", {bus.overrun, bus.frame_err}); end
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL single_empty got %0b want 0", bus.rx_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] msg [4];
    msg[0] = 8'h63; msg[1] = 8'h72; msg[2] = 8'h63; msg[3] = 8'h0A;
    rcvq.delete();
    expq.delete();
    for (int i = 0; i < 4; i++) begin
      send_frame(msg[i], 1'b1);
      expq.push_back(msg[i]);
    end
    tick(CPB);
    checks++; if (bus.rx_count !== 5'(expq.size())) begin errors++; $display("FAIL b2b_count got %0d want %0d", bus.rx_count, expq.size()); end
    checks++; if (bus.rx_data !== expq[0]) begin errors++; $display("FAIL b2b_head got %02h want %02h", bus.rx_data, expq[0]); end
    drain();
    checks++; if (rcvq.size() !== expq.size()) begin errors++; $display("FAIL b2b_drain_len got %0d want %0d", rcvq.size(), expq.size()); end
    for (int i = 0; i < expq.size() && i < rcvq.size(); i++) begin
      checks++; if (rcvq[i] !== expq[i]) begin errors++; $display("FAIL b2b_byte%0d got %02h want %02h", i, rcvq[i], expq[i]); end
    end
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %0b want 0", bus.rx_valid); end
  endtask

  task automatic test_overrun();
    logic exp_ovr;
    rcvq.delete();
    expq.delete();
    exp_ovr = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      send_frame(8'(i), 1'b1);
      if (expq.size() < D) expq.push_back(8'(i));
      else exp_ovr = 1'b1;
    end
    tick(CPB);
    checks++; if (bus.rx_count !== 5'(expq.size())) begin errors++; $display("FAIL ovr_count got %0d want %0d", bus.rx_count, expq.size()); end
    checks++; if (bus.overrun !== exp_ovr) begin errors++; $display("FAIL ovr_flag got %0b want %0b", bus.overrun, exp_ovr); end
    drain();
    checks++; if (rcvq.size() !== expq.size()) begin errors++; $display("FAIL ovr_drain_len got %0d want %0d", rcvq.size(), expq.size()); end
    for (int i = 0; i < expq.size() && i < rcvq.size(); i++) begin
      checks++; if (rcvq[i] !== expq[i]) begin errors++; $display("FAIL ovr_byte%0d got %02h want %02h", i, rcvq[i], expq[i]); end
    end
    pulse_clr();
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %0b want 0", bus.overrun); end
  endtask

  task automatic test_frame_err();
    rcvq.delete();
    send_frame(8'h55, 1'b0);
    uart_rx = 1'b0;
    tick(2 * CPB);
    uart_rx = 1'b1;
    tick(2 * CPB);
    checks++; if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL ferr_flag got %0b want 1", bus.frame_err); end
    checks++; if (bus.rx_count !== 5'd0) begin errors++; $display("FAIL ferr_nopush got %0d want 0", bus.rx_count); end
    send_frame(8'hA5, 1'b1);
    tick(CPB);
    checks++; if (bus.rx_count !== 5'd1) begin errors++; $display("FAIL ferr_next_count got %0d want 1", bus.rx_count); end
    drain();
    checks++; if (rcvq.size() !== 1 || rcvq[0] !== 8'hA5) begin errors++; $display("FAIL ferr_next_data got n=%0d first=%02h want n=1 a5", rcvq.size(), rcvq.size() > 0 ? rcvq[0] : 8'hxx); end
    pulse_clr();
    checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clear got %0b want 0", bus.frame_err); end
  endtask

  task automatic test_glitch();
    uart_rx = 1'b0;
    tick(CPB / 4);
    uart_rx = 1'b1;
    tick(2 * CPB);
    checks++; if (bus.rx_count !== 5'd0) begin errors++; $display("FAIL glitch_count got %0d want 0", bus.rx_count); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got %0b want 0", bus.busy); end
    checks++; if ({bus.overrun, bus.frame_err} !== 2'b00) begin errors++; $display("FAIL glitch_flags got %02b want 00", {bus.overrun, bus.frame_err}); end
  endtask

  task automatic test_reset_midframe();
    rcvq.delete();
    send_frame(8'h11, 1'b1);
    uart_rx = 1'b0;
    tick(CPB);
    uart_rx = 1'b1; tick(CPB);
    uart_rx = 1'b0; tick(CPB);
    uart_rx = 1'b1; tick(CPB);
    uart_rx = 1'b0; tick(CPB / 2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++; if (bus.rx_count !== 5'd0) begin errors++; $display("FAIL rstmid_count got %0d want 0", bus.rx_count); end
    tick(4 * CPB);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy got %0b want 1", bus.busy); end
    uart_rx = 1'b1;
    tick(2 * CPB);
    checks++; if ({bus.frame_err, bus.rx_count} !== 6'd0) begin errors++; $display("FAIL rstmid_false_frame got ferr=%0b count=%0d want 0 0", bus.frame_err, bus.rx_count); end
    send_frame(8'h3C, 1'b1);
    tick(CPB);
    drain();
    checks++; if (rcvq.size() !== 1 || rcvq[0] !== 8'h3C) begin errors++; $display("FAIL rstmid_data got n=%0d first=%02h want n=1 3c", rcvq.size(), rcvq.size() > 0 ? rcvq[0] : 8'hxx); end
  endtask

  task automatic test_random_stream();
    logic done;
    rcvq.delete();
    expq.delete();
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          logic [7:0] b;
          b = 8'($urandom);
          expq.push_back(b);
          send_frame(b, 1'b1);
          if ($urandom_range(0, 1) == 1) tick($urandom_range(1, CPB));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          bus.rx_ready = 1'($urandom_range(0, 1));
          tick(1);
        end
      end
    join
    bus.rx_ready = 1'b0;
    tick(CPB);
    drain();
    checks++; if (rcvq.size() !== expq.size()) begin errors++; $display("FAIL rand_len got %0d want %0d", rcvq.size(), expq.size()); end
    for (int i = 0; i < expq.size() && i < rcvq.size(); i++) begin
      checks++; if (rcvq[i] !== expq[i]) begin errors++; $display("FAIL rand_byte%0d got %02h want %02h", i, rcvq[i], expq[i]); end
    end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL rand_overrun got %0b want 0", bus.overrun); end
  endtask

  initial begin
    bus.rx_ready = 1'b0;
    bus.err_clr  = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_reset_midframe();
    test_random_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
